// File: rtl/apb_pkg.sv
// Shared types and widths for the APB register completer.
package apb_pkg;

  typedef enum logic {APB_IDLE, APB_ACCESS} apb_slv_state_t;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;

endpackage

// File: rtl/apb_wait_ctr.sv
// Access-phase wait-state down-counter; ready_next flags the edge that raises PREADY.
module apb_wait_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       ready_next
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign ready_next = dec && (cnt == 4'd1);

endmodule

// File: rtl/apb_slave_regs.sv
// APB3 completer with NUM_REGS control registers (reg 0 = read-only ID) and fixed wait states.
// Optional byte-lane strobes via `define APB_SLV_PSTRB_EN (adds PSTRB[3:0]).
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [APB_ADDR_W-1:0]   PADDR,
  input  logic [APB_DATA_W-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
  input  logic [3:0]              PSTRB,
`endif
  output logic [APB_DATA_W-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [NUM_REGS*32-1:0]  reg_q
);

  localparam int                    IDX_W      = $clog2(NUM_REGS);
  localparam logic [APB_ADDR_W-1:0] ADDR_LIMIT = APB_ADDR_W'(NUM_REGS * 4);
  localparam logic [3:0]            WS         = 4'(WAIT_STATES);

  apb_slv_state_t        state;
  logic [APB_DATA_W-1:0] regs [1:NUM_REGS-1];
  logic [IDX_W-1:0]      idx;
  logic                  err;
  logic [APB_DATA_W-1:0] rd_resp;
  logic [3:0]            strb;
  logic                  setup;
  logic                  wait_dec;
  logic                  ready_next;

`ifdef APB_SLV_PSTRB_EN
  assign strb = PSTRB;
`else
  assign strb = 4'hF;
`endif

  always_comb begin
    idx     = PADDR[2 +: IDX_W];
    err     = (PADDR[1:0] != 2'b00) | (PADDR >= ADDR_LIMIT) | (PWRITE & (idx == '0));
    rd_resp = '0;
    if (!PWRITE && !err) begin
      rd_resp = (idx == '0) ? ID_VALUE : regs[idx];
    end
  end

  assign setup    = (state == APB_IDLE) && PSEL && !PENABLE;
  assign wait_dec = (state == APB_ACCESS) && PSEL && PENABLE && !PREADY;

  apb_wait_ctr u_wait_ctr (
    .clk        (PCLK),
    .rst_n      (PRESETn),
    .load       (setup),
    .load_val   (WS),
    .dec        (wait_dec),
    .ready_next (ready_next)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= APB_IDLE;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        APB_IDLE: begin
          if (setup) begin
            state <= APB_ACCESS;
            if (WS == 4'd0) begin
              PREADY  <= 1'b1;
              PSLVERR <= err;
              PRDATA  <= rd_resp;
            end
          end
        end
        APB_ACCESS: begin
          if (!PSEL) begin
            state   <= APB_IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
          end else if (PENABLE) begin
            if (PREADY) begin
              // Commit uses the decode of the held address; err excludes index 0.
              if (PWRITE && !err) begin
                for (int unsigned k = 0; k < 4; k++) begin
                  if (strb[k]) regs[idx][8*k +: 8] <= PWDATA[8*k +: 8];
                end
              end
              state   <= APB_IDLE;
              PREADY  <= 1'b0;
              PSLVERR <= 1'b0;
              PRDATA  <= '0;
            end else if (ready_next) begin
              PREADY  <= 1'b1;
              PSLVERR <= err;
              PRDATA  <= rd_resp;
            end
          end
        end
        default: state <= APB_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
    if (i == 0) begin : g_id
      assign reg_q[31:0] = ID_VALUE;
    end else begin : g_rw
      assign reg_q[32*i +: 32] = regs[i];
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench: a WAIT_STATES=1 instance for the vector table and a WAIT_STATES=3 instance for abort.
module tb_apb_slave_regs;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         psel_f, psel_s, penable, pwrite;
  logic [31:0]  paddr, pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata_f, prdata_s;
  logic         pready_f, pready_s, pslverr_f, pslverr_s;
  logic [255:0] reg_q_f, reg_q_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_slave_regs #(.NUM_REGS(8), .WAIT_STATES(1), .ID_VALUE(ID)) u_dut (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_f), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata_f), .PREADY(pready_f), .PSLVERR(pslverr_f), .reg_q(reg_q_f)
  );

  apb_slave_regs #(.NUM_REGS(8), .WAIT_STATES(3), .ID_VALUE(ID)) u_dut_slow (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_s), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata_s), .PREADY(pready_s), .PSLVERR(pslverr_s), .reg_q(reg_q_s)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model_f [8];
  logic [31:0] model_s [8];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pack(input logic [31:0] m [8]);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = m[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      model_f[i] = '0;
      model_s[i] = '0;
    end
    model_f[0] = ID;
    model_s[0] = ID;
  endfunction

  // Called at a negedge; returns at the negedge after the completion edge.
  task automatic xfer(input bit slow, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [31:0] rdata, output bit err, output int cycles);
    int n;
    if (slow) psel_s = 1'b1; else psel_f = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    n = 1;
    while (!(slow ? pready_s : pready_f) && n < 40) begin
      @(negedge clk);
      n++;
    end
    cycles = n + 1;
    rdata  = slow ? prdata_s : prdata_f;
    err    = slow ? pslverr_s : pslverr_f;
    if (!(slow ? pready_s : pready_f)) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout addr %h: PREADY never rose", addr);
    end
    @(negedge clk);
    check("outputs_cleared", slow ? {pready_s, pslverr_s, prdata_s} : {pready_f, pslverr_f, prdata_f}, '0);
    psel_f = 1'b0; psel_s = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    bit          er;
    int          cyc;
    bit          seen;

    rst_n = 1'b0; psel_f = 1'b0; psel_s = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = 4'hF;
    model_reset();

    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         ID,            1'b0});
    vecs.push_back('{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0,         1'b1});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0,         1'b1});
    vecs.push_back('{1'b1, 32'h0000_0006, 32'h1234_5678, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h0000_000A, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{1'b1, 32'h0000_001C, 32'hCAFE_F00D, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h0000_001C, 32'h0,         32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b1, 32'h0000_0004, 32'h0000_00FF, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,         32'h0000_00FF, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         ID,            1'b0});

    repeat (2) @(negedge clk);
    check("reset_outputs", {pready_f, pslverr_f, prdata_f}, '0);
    check("reset_reg_q", reg_q_f, pack(model_f));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {pready_f, pslverr_f, prdata_f}, '0);

    foreach (vecs[i]) begin
      xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'hF, rd, er, cyc);
      if (vecs[i].wr && !vecs[i].exp_err) model_f[vecs[i].addr[4:2]] = vecs[i].wdata;
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_pslverr", i), er, vecs[i].exp_err);
      check($sformatf("vec%0d_cycles", i), cyc, 3);
      check($sformatf("vec%0d_reg_q", i), reg_q_f, pack(model_f));
    end

    // PENABLE with PSEL while idle must be ignored.
    psel_f = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h8;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pready_f) seen = 1'b1;
    end
    check("idle_penable_ignored", seen, 1'b0);
    psel_f = 1'b0; penable = 1'b0;
    @(negedge clk);
    xfer(1'b0, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, cyc);
    check("after_violation_rdata", rd, 32'hDEAD_BEEF);
    check("after_violation_cycles", cyc, 3);

    // Reset asserted while a write response is pending.
    psel_f = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0000_0077;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check("midreset_pready_before", pready_f, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midreset_pready_now", pready_f, 1'b0);
    psel_f = 1'b0; penable = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_reg_q", reg_q_f, pack(model_f));
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, cyc);
    check("midreset_read", rd, 32'h0);

    // Slow instance: normal write, then an aborted write.
    xfer(1'b1, 1'b1, 32'h4, 32'h0000_5555, 4'hF, rd, er, cyc);
    model_s[1] = 32'h0000_5555;
    check("slow_write_cycles", cyc, 5);
    check("slow_write_err", er, 1'b0);
    psel_s = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h0000_1234;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    seen = pready_s;
    psel_s = 1'b0; penable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (pready_s) seen = 1'b1;
    end
    check("abort_no_pready", seen, 1'b0);
    check("abort_reg_q", reg_q_s, pack(model_s));
    xfer(1'b1, 1'b0, 32'hC, 32'h0, 4'hF, rd, er, cyc);
    check("abort_read_c", rd, 32'h0);
    check("abort_read_cycles", cyc, 5);
    xfer(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, rd, er, cyc);
    check("abort_read_4", rd, 32'h0000_5555);

`ifdef APB_SLV_PSTRB_EN
    xfer(1'b0, 1'b1, 32'h4, 32'h1122_3344, 4'hF, rd, er, cyc);
    xfer(1'b0, 1'b1, 32'h4, 32'hAABB_CCDD, 4'b0101, rd, er, cyc);
    check("strb_err", er, 1'b0);
    xfer(1'b0, 1'b0, 32'h4, 32'h0, 4'hF, rd, er, cyc);
    check("strb_merge", rd, 32'h11BB_33DD);
    xfer(1'b0, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0000, rd, er, cyc);
    check("strb_zero_err", er, 1'b0);
    xfer(1'b0, 1'b0, 32'h4, 32'h0, 4'hF, rd, er, cyc);
    check("strb_zero_unchanged", rd, 32'h11BB_33DD);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_regs.md
Name: apb_slave_regs

Overview:
- APB3 completer that sits directly downstream of the bridge's APB master and consumes its PSEL/PENABLE/PADDR/PWRITE/PWDATA transfers.
- Holds a bank of NUM_REGS 32-bit control registers and inserts a fixed, parameterised number of wait states.
- Flags unmapped, misaligned and read-only accesses with PSLVERR.
- Exposes register contents to the rest of the design.

Parameters:
- NUM_REGS, 8, number of 32-bit registers (2..256); register 0 is a read-only ID.
- WAIT_STATES, 1, access-phase wait cycles before PREADY (0..15).
- ID_VALUE, 32'hA9B0_0001, constant returned by register 0.

Ports:
- PCLK  input  1  bus clock; all logic on its rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- PSEL  input  1  select from APB master.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  32  byte address, offset from slave base.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data, valid when PREADY=1.
- PREADY  output  1  transfer completion.
- PSLVERR  output  1  error response, valid when PREADY=1.
- reg_q  output  NUM_REGS*32  flattened register contents; reg i at bits [32*i+:32], reg 0 = ID_VALUE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0.
  - Registers 1..NUM_REGS-1 = 0; wait counter = 0.
- States: IDLE, ACCESS (2-state enum, distinct encodings).
- IDLE:
  - Sampling PSEL=1, PENABLE=0 (setup phase) loads cnt<=WAIT_STATES and goes to ACCESS.
  - If WAIT_STATES==0, PREADY<=1 at that same edge and the response is loaded there.
- ACCESS, each edge with PSEL=1, PENABLE=1, PREADY=0:
  - cnt<=cnt-1.
  - When cnt==1, PREADY<=1 and the response is loaded.
- Response load:
  - Decode index = PADDR[2+:$clog2(NUM_REGS)].
  - err = (PADDR[1:0]!=0) | (PADDR >= NUM_REGS*4) | (PWRITE & index==0).
  - PSLVERR<=err.
  - PRDATA <= (!PWRITE & !err) ? reg[index] : 0.
- Completion edge (PSEL=1, PENABLE=1, PREADY=1 sampled):
  - If PWRITE & !err, reg[index]<=PWDATA.
  - PREADY, PSLVERR and PRDATA return to 0; state->IDLE.
- Write commit happens only on the completion edge. Errored writes leave all registers unchanged.
- Latency: transfer takes 2+WAIT_STATES PCLK cycles, setup included.
- Back-to-back: a new setup phase in the cycle after completion is accepted normally. IDLE is entered at the completion edge, so no extra bubble.
- Abort: PSEL=0 sampled in ACCESS before completion → IDLE, no write, outputs cleared.
- PENABLE=1 with PSEL=1 sampled in IDLE (protocol violation): ignored, stay IDLE.
- Address/control are sampled at the response-load edge. The master must hold them stable per APB rules. No internal capture is required beyond that.
- Reset asserted mid-transfer: immediate return to reset values; a pending write is discarded.

Optional Feature:
- APB_SLV_PSTRB_EN defined:
  - Adds input PSTRB[3:0].
  - On write commit, byte lane k of reg[index] is updated only if PSTRB[k]=1.
  - A write with PSTRB==0 completes with PSLVERR=0 and changes nothing.
- Undefined: no PSTRB port; all four lanes are written.

Decomposition:
- Package apb_pkg holds:
  - typedef enum logic {APB_IDLE, APB_ACCESS} apb_slv_state_t;
  - localparam APB_DATA_W=32, APB_ADDR_W=32.
- Sub-module apb_wait_ctr: 4-bit down-counter with load/decrement/ready-next outputs, instantiated once.
- Register bank and decode stay in apb_slave_regs.

Test Plan:
- Reset, then read PADDR=0 with WAIT_STATES=1 → PREADY high in 3rd cycle, PRDATA=32'hA9B0_0001, PSLVERR=0.
- Write PADDR=0x8, PWDATA=32'hDEAD_BEEF, then read 0x8 → reg_q[95:64]=32'hDEAD_BEEF after completion edge; read returns same, PSLVERR=0.
- Write PADDR=0x0 or PADDR=0x20 (NUM_REGS=8) or PADDR=0x6 → PSLVERR=1 with PREADY, all registers unchanged, PRDATA=0.
- PSEL dropped after setup and 1 access cycle with WAIT_STATES=3 → no PREADY pulse, register unchanged; following normal read completes correctly.
- PRESETn pulsed low during ACCESS of a write → PREADY=0 immediately, written register remains 0.
- APB_SLV_PSTRB_EN: reg1=32'h1122_3344, write 32'hAABB_CCDD with PSTRB=4'b0101 → reg1=32'h11BB_33DD.
